rx_block_reader: RTL and testbench

RX_BLOCK_READER -- requirements
Module: rx_block_reader

---
 rtl/rx_block_reader_pkg.sv | 29 ++
 rtl/rx_block_reader_if.sv | 21 ++
 rtl/rx_block_reader.sv | 158 +++++++++++++++
 tb/tb_rx_block_reader.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_block_reader_pkg.sv
// -----------------------------------------------------------------------------
// rx_block_reader_pkg
// Shared definitions for the UART receive path: drain FSM state encoding,
// byte width, ping-pong buffer base constants and the block-length clamp.
// No ports (package).
// -----------------------------------------------------------------------------
package rx_block_reader_pkg;

    localparam int unsigned BYTE_W             = 8;
    localparam int unsigned DEFAULT_BLOCK_SIZE = 16;
    // Half A always starts at address 0; half B starts at the block size.
    localparam int unsigned HALF_A_BASE        = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        WAIT = 2'd2,
        SEND = 2'd3
    } state_t;

    // A block never extends past its own ping-pong half.
    function automatic logic [BYTE_W-1:0] clamp_len(
        input logic [BYTE_W-1:0] count,
        input logic [BYTE_W-1:0] limit
    );
        return (count > limit) ? limit : count;
    endfunction

endpackage

// File: rtl/rx_block_reader_if.sv
// -----------------------------------------------------------------------------
// rx_block_reader_if
// Byte-stream handshake carrying drained bytes downstream.
//   m_data  : streamed byte
//   m_valid : m_data valid
//   m_ready : downstream accepts (transfer on m_valid & m_ready)
//   m_last  : final byte of a block, qualified by m_valid
// master = byte source (rx_block_reader), slave = byte sink.
// -----------------------------------------------------------------------------
interface rx_block_reader_if;
    import rx_block_reader_pkg::*;

    logic [BYTE_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic              m_last;

    modport master (output m_data, output m_valid, output m_last, input m_ready);
    modport slave  (input m_data, input m_valid, input m_last, output m_ready);

endinterface

// File: rtl/rx_block_reader.sv
// -----------------------------------------------------------------------------
// rx_block_reader
// Drains a completed receive block out of one half of the ping-pong byte
// buffer and streams it downstream, one byte every three cycles at best
// (ADDR -> WAIT -> SEND).
// Ports:
//   clk, reset                : clock, synchronous active-high reset
//   rx_done                   : block complete; rising edge starts a drain
//   message_received_count    : bytes in the completed block
//   pingpong_pointer          : half holding the block (0 = A, 1 = B)
//   data_buffer_readaddress   : buffer read address
//   data_buffer_readdata      : buffer read data, one cycle after the address
//   busy                      : drain in progress
//   overrun_flag              : sticky, a block was dropped
//   clear_overrun             : pulse clears overrun_flag (a new overrun wins)
//   stream                    : byte stream output (master modport)
// -----------------------------------------------------------------------------
module rx_block_reader
    import rx_block_reader_pkg::*;
#(
    parameter int DATA_BUFFER_LENGTH_WIDTH = 8,
    parameter int DATA_BLOCK_SIZE          = DEFAULT_BLOCK_SIZE
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                rx_done,
    input  logic [BYTE_W-1:0]                   message_received_count,
    input  logic                                pingpong_pointer,
    output logic [DATA_BUFFER_LENGTH_WIDTH-1:0] data_buffer_readaddress,
    input  logic [BYTE_W-1:0]                   data_buffer_readdata,
    output logic                                busy,
    output logic                                overrun_flag,
    input  logic                                clear_overrun,
    rx_block_reader_if.master                   stream
);

    localparam int AW = DATA_BUFFER_LENGTH_WIDTH;
    localparam logic [AW-1:0]     BASE_A    = AW'(HALF_A_BASE);
    localparam logic [AW-1:0]     BASE_B    = AW'(DATA_BLOCK_SIZE);
    localparam logic [BYTE_W-1:0] BLOCK_LEN = BYTE_W'(DATA_BLOCK_SIZE);

    state_t              state, state_n;
    logic [AW-1:0]       base, base_n;
    logic [AW-1:0]       addr, addr_n;
    logic [BYTE_W-1:0]   len, len_n;
    logic [BYTE_W-1:0]   idx, idx_n;
    logic [BYTE_W-1:0]   data, data_n;
    logic                valid, valid_n;
    logic                last, last_n;
    logic                overrun, overrun_n;
    logic                rx_done_q;
    logic                armed;
    logic                start;
    logic                start_ok;
    logic                transfer;
    logic                final_xfer;

    // armed keeps an rx_done that is already high at reset release from
    // looking like a fresh edge; it re-arms once rx_done has been seen low.
    assign start    = rx_done & ~rx_done_q & armed;
    assign start_ok = start && (message_received_count != '0);

    // m_valid is high throughout SEND, so a transfer is SEND & m_ready.
    assign transfer   = (state == SEND) && stream.m_ready;
    assign final_xfer = transfer && (idx == len - 1'b1);

    always_comb begin
        state_n   = state;
        base_n    = base;
        len_n     = len;
        idx_n     = idx;
        addr_n    = addr;
        data_n    = data;
        overrun_n = overrun & ~clear_overrun;

        case (state)
            IDLE: begin
                if (start_ok) begin
                    state_n = ADDR;
                    base_n  = pingpong_pointer ? BASE_B : BASE_A;
                    len_n   = clamp_len(message_received_count, BLOCK_LEN);
                    idx_n   = '0;
                end
            end
            ADDR: state_n = WAIT;
            WAIT: begin
                state_n = SEND;
                data_n  = data_buffer_readdata;
            end
            SEND: begin
                if (final_xfer) begin
                    // A start landing on the last-byte transfer chains
                    // straight into the next block instead of overrunning.
                    if (start_ok) begin
                        state_n = ADDR;
                        base_n  = pingpong_pointer ? BASE_B : BASE_A;
                        len_n   = clamp_len(message_received_count, BLOCK_LEN);
                        idx_n   = '0;
                    end else begin
                        state_n = IDLE;
                    end
                end else if (transfer) begin
                    state_n = ADDR;
                    idx_n   = idx + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        if (start_ok && (state != IDLE) && !final_xfer)
            overrun_n = 1'b1;

        // The address register is loaded on entry to ADDR so the buffer sees
        // it during ADDR; it holds in every other state.
        if (state_n == ADDR)
            addr_n = base_n + AW'(idx_n);

        valid_n = (state_n == SEND);
        last_n  = (state_n == SEND) && (idx_n == len_n - 1'b1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            base      <= '0;
            len       <= '0;
            idx       <= '0;
            addr      <= '0;
            data      <= '0;
            valid     <= 1'b0;
            last      <= 1'b0;
            overrun   <= 1'b0;
            rx_done_q <= 1'b0;
            armed     <= ~rx_done;
        end else begin
            state     <= state_n;
            base      <= base_n;
            len       <= len_n;
            idx       <= idx_n;
            addr      <= addr_n;
            data      <= data_n;
            valid     <= valid_n;
            last      <= last_n;
            overrun   <= overrun_n;
            rx_done_q <= rx_done;
            if (!rx_done)
                armed <= 1'b1;
        end
    end

    assign data_buffer_readaddress = addr;
    assign busy                    = (state != IDLE);
    assign overrun_flag            = overrun;
    assign stream.m_data           = data;
    assign stream.m_valid          = valid;
    assign stream.m_last           = last;

endmodule

// File: tb/tb_rx_block_reader.sv
// -----------------------------------------------------------------------------
// tb_rx_block_reader
// Self-checking bench for rx_block_reader: a registered buffer model feeds the
// DUT, expected {last, byte} entries are queued when a block is started and
// popped by a monitor on every accepted transfer; scenario tasks add their own
// cycle-exact checks.
// -----------------------------------------------------------------------------
module tb_rx_block_reader;
    import rx_block_reader_pkg::*;

    localparam int AW = 8;
    localparam int BS = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          rx_done;
    logic [7:0]    message_received_count;
    logic          pingpong_pointer;
    logic [AW-1:0] data_buffer_readaddress;
    logic [7:0]    data_buffer_readdata;
    logic          busy;
    logic          overrun_flag;
    logic          clear_overrun;

    rx_block_reader_if sif ();

    rx_block_reader #(
        .DATA_BUFFER_LENGTH_WIDTH(AW),
        .DATA_BLOCK_SIZE(BS)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rx_done(rx_done),
        .message_received_count(message_received_count),
        .pingpong_pointer(pingpong_pointer),
        .data_buffer_readaddress(data_buffer_readaddress),
        .data_buffer_readdata(data_buffer_readdata),
        .busy(busy),
        .overrun_flag(overrun_flag),
        .clear_overrun(clear_overrun),
        .stream(sif)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:255];
    always @(posedge clk) data_buffer_readdata <= mem[data_buffer_readaddress];

    logic [8:0] sb [$];
    logic [8:0] mon_exp;
    int compared   = 0;
    int mismatched = 0;

    // Scoreboard monitor: every accepted byte must match the queue head.
    always @(negedge clk) begin
        if (!reset && sif.m_valid && sif.m_ready) begin
            compared++;
            if (sb.size() == 0) begin
                mismatched++;
                $display("FAIL stream_unexpected: got last=%0b data=%02h, expected nothing", sif.m_last, sif.m_data);
            end else begin
                mon_exp = sb.pop_front();
                if ({sif.m_last, sif.m_data} !== mon_exp) begin
                    mismatched++;
                    $display("FAIL stream_byte: got last=%0b data=%02h, expected last=%0b data=%02h",
                             sif.m_last, sif.m_data, mon_exp[8], mon_exp[7:0]);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference model of one drained block.
    task automatic push_block(input logic ptr, input int count);
        int len;
        int base;
        len  = (count > BS) ? BS : count;
        base = ptr ? BS : 0;
        for (int i = 0; i < len; i++)
            sb.push_back({(i == len - 1) ? 1'b1 : 1'b0, mem[base + i]});
    endtask

    task automatic test_reset;
        reset = 1'b1; rx_done = 1'b0; message_received_count = '0;
        pingpong_pointer = 1'b0; clear_overrun = 1'b0; sif.m_ready = 1'b0;
        tick; tick; tick;
        compared++; if (data_buffer_readaddress !== '0) begin mismatched++; $display("FAIL reset_addr: got %0d, expected 0", data_buffer_readaddress); end
        compared++; if (sif.m_data !== 8'h00) begin mismatched++; $display("FAIL reset_data: got %02h, expected 00", sif.m_data); end
        compared++; if (sif.m_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %0b, expected 0", sif.m_valid); end
        compared++; if (sif.m_last !== 1'b0) begin mismatched++; $display("FAIL reset_last: got %0b, expected 0", sif.m_last); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %0b, expected 0", busy); end
        compared++; if (overrun_flag !== 1'b0) begin mismatched++; $display("FAIL reset_overrun: got %0b, expected 0", overrun_flag); end
        reset = 1'b0;
        tick;
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_idle_after: busy got %0b, expected 0", busy); end
    endtask

    task automatic test_basic;
        logic ev;
        sif.m_ready = 1'b1; pingpong_pointer = 1'b0; message_received_count = 8'd3;
        push_block(1'b0, 3);
        rx_done = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            tick;
            if (c == 2) rx_done = 1'b0;
            ev = (c == 3 || c == 6 || c == 9);
            compared++; if (sif.m_valid !== ev) begin mismatched++; $display("FAIL basic_valid c=%0d: got %0b, expected %0b", c, sif.m_valid, ev); end
            if (ev) begin
                compared++; if (sif.m_last !== (c == 9)) begin mismatched++; $display("FAIL basic_last c=%0d: got %0b, expected %0b", c, sif.m_last, c == 9); end
            end
            compared++; if (busy !== (c <= 9)) begin mismatched++; $display("FAIL basic_busy c=%0d: got %0b, expected %0b", c, busy, c <= 9); end
            if (c == 1 || c == 4 || c == 7) begin
                compared++; if (data_buffer_readaddress !== AW'((c - 1) / 3)) begin mismatched++; $display("FAIL basic_addr c=%0d: got %0d, expected %0d", c, data_buffer_readaddress, (c - 1) / 3); end
            end
        end
        compared++; if (sb.size() != 0) begin mismatched++; $display("FAIL basic_drained: %0d bytes left, expected 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_pointer_b_stall;
        sif.m_ready = 1'b0; pingpong_pointer = 1'b1; message_received_count = 8'd2;
        push_block(1'b1, 2);
        rx_done = 1'b1;
        for (int c = 1; c <= 13; c++) begin
            tick;
            if (c == 2) rx_done = 1'b0;
            if (c == 1) begin
                compared++; if (data_buffer_readaddress !== AW'(16)) begin mismatched++; $display("FAIL ptrb_addr0: got %0d, expected 16", data_buffer_readaddress); end
            end
            if (c >= 3 && c <= 8) begin
                compared++; if ({sif.m_valid, sif.m_last, sif.m_data} !== {2'b10, 8'h55}) begin mismatched++; $display("FAIL ptrb_hold c=%0d: got valid=%0b last=%0b data=%02h, expected 1 0 55", c, sif.m_valid, sif.m_last, sif.m_data); end
            end
            if (c == 8) sif.m_ready = 1'b1;
            if (c == 9) begin
                compared++; if (data_buffer_readaddress !== AW'(17)) begin mismatched++; $display("FAIL ptrb_addr1: got %0d, expected 17", data_buffer_readaddress); end
            end
            if (c == 12) begin
                compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL ptrb_busy_end: got %0b, expected 0", busy); end
            end
        end
        compared++; if (sb.size() != 0) begin mismatched++; $display("FAIL ptrb_drained: %0d bytes left, expected 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_clamp;
        sif.m_ready = 1'b1; pingpong_pointer = 1'b0; message_received_count = 8'd20;
        push_block(1'b0, 20);
        rx_done = 1'b1;
        tick;
        rx_done = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (sb.size() == 0 && !busy) break;
            tick;
        end
        tick;
        compared++; if (sb.size() != 0 || busy !== 1'b0) begin mismatched++; $display("FAIL clamp_done: left=%0d busy=%0b, expected 0 0", sb.size(), busy); sb.delete(); end
    endtask

    task automatic test_zero_count;
        sif.m_ready = 1'b1; pingpong_pointer = 1'b0; message_received_count = 8'd0;
        rx_done = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick;
            compared++; if (sif.m_valid !== 1'b0 || busy !== 1'b0) begin mismatched++; $display("FAIL zero_idle c=%0d: valid=%0b busy=%0b, expected 0 0", c, sif.m_valid, busy); end
        end
        compared++; if (overrun_flag !== 1'b0) begin mismatched++; $display("FAIL zero_overrun: got %0b, expected 0", overrun_flag); end
        rx_done = 1'b0;
        tick;
    endtask

    task automatic test_overrun;
        sif.m_ready = 1'b1; pingpong_pointer = 1'b0; message_received_count = 8'd4;
        push_block(1'b0, 4);
        rx_done = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            tick;
            if (c == 2) rx_done = 1'b0;
            if (c == 4) begin
                // New block arrives mid-drain together with a clear pulse.
                rx_done = 1'b1; pingpong_pointer = 1'b1; message_received_count = 8'd2;
                clear_overrun = 1'b1;
            end
            if (c == 5) begin
                clear_overrun = 1'b0;
                compared++; if (overrun_flag !== 1'b1) begin mismatched++; $display("FAIL overrun_set: got %0b, expected 1", overrun_flag); end
            end
            if (c == 6) rx_done = 1'b0;
        end
        compared++; if (sb.size() != 0 || busy !== 1'b0) begin mismatched++; $display("FAIL overrun_first_intact: left=%0d busy=%0b, expected 0 0", sb.size(), busy); sb.delete(); end
        compared++; if (overrun_flag !== 1'b1) begin mismatched++; $display("FAIL overrun_sticky: got %0b, expected 1", overrun_flag); end
    endtask

    task automatic test_clear_overrun;
        clear_overrun = 1'b1;
        tick;
        clear_overrun = 1'b0;
        compared++; if (overrun_flag !== 1'b0) begin mismatched++; $display("FAIL clear_overrun: got %0b, expected 0", overrun_flag); end
    endtask

    task automatic test_back_to_back;
        sif.m_ready = 1'b1; pingpong_pointer = 1'b0; message_received_count = 8'd3;
        push_block(1'b0, 3);
        rx_done = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick;
            if (c == 2) rx_done = 1'b0;
            if (c == 9) begin
                rx_done = 1'b1; pingpong_pointer = 1'b1; message_received_count = 8'd2;
                push_block(1'b1, 2);
            end
            if (c == 10) begin
                rx_done = 1'b0;
                compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL b2b_accepted: busy got %0b, expected 1", busy); end
                compared++; if (data_buffer_readaddress !== AW'(16)) begin mismatched++; $display("FAIL b2b_addr: got %0d, expected 16", data_buffer_readaddress); end
            end
            if (c == 12) begin
                compared++; if (sif.m_valid !== 1'b1) begin mismatched++; $display("FAIL b2b_first_valid: got %0b, expected 1", sif.m_valid); end
            end
        end
        for (int i = 0; i < 20; i++) begin
            if (sb.size() == 0 && !busy) break;
            tick;
        end
        compared++; if (sb.size() != 0 || busy !== 1'b0) begin mismatched++; $display("FAIL b2b_done: left=%0d busy=%0b, expected 0 0", sb.size(), busy); sb.delete(); end
        compared++; if (overrun_flag !== 1'b0) begin mismatched++; $display("FAIL b2b_no_overrun: got %0b, expected 0", overrun_flag); end
    endtask

    task automatic test_reset_mid_drain;
        sif.m_ready = 1'b1; pingpong_pointer = 1'b0; message_received_count = 8'd4;
        push_block(1'b0, 4);
        rx_done = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick;
            if (c == 2) rx_done = 1'b0;
            if (c == 4) sif.m_ready = 1'b0;
        end
        compared++; if (sif.m_valid !== 1'b1 || sif.m_data !== mem[1]) begin mismatched++; $display("FAIL rstmid_byte2: valid=%0b data=%02h, expected 1 %02h", sif.m_valid, sif.m_data, mem[1]); end
        reset = 1'b1;
        tick;
        compared++; if (sif.m_valid !== 1'b0) begin mismatched++; $display("FAIL rstmid_valid: got %0b, expected 0", sif.m_valid); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL rstmid_busy: got %0b, expected 0", busy); end
        compared++; if (data_buffer_readaddress !== '0) begin mismatched++; $display("FAIL rstmid_addr: got %0d, expected 0", data_buffer_readaddress); end
        reset = 1'b0;
        sb.delete();
        tick;
    endtask

    task automatic test_held_rx_done;
        sif.m_ready = 1'b1; pingpong_pointer = 1'b0; message_received_count = 8'd2;
        reset = 1'b1; rx_done = 1'b1;
        tick; tick;
        reset = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            tick;
            compared++; if (busy !== 1'b0 || sif.m_valid !== 1'b0) begin mismatched++; $display("FAIL held_no_start c=%0d: busy=%0b valid=%0b, expected 0 0", c, busy, sif.m_valid); end
        end
        rx_done = 1'b0;
        tick;
        push_block(1'b0, 2);
        rx_done = 1'b1;
        tick;
        rx_done = 1'b0;
        compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL held_fresh_edge: busy got %0b, expected 1", busy); end
        for (int i = 0; i < 30; i++) begin
            if (sb.size() == 0 && !busy) break;
            tick;
        end
        compared++; if (sb.size() != 0 || busy !== 1'b0) begin mismatched++; $display("FAIL held_done: left=%0d busy=%0b, expected 0 0", sb.size(), busy); sb.delete(); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
        mem[0] = 8'hA1; mem[1] = 8'hB2; mem[2] = 8'hC3;
        mem[16] = 8'h55; mem[17] = 8'hAA;
        sif.m_ready = 1'b0;

        test_reset;
        test_basic;
        test_pointer_b_stall;
        test_clamp;
        test_zero_count;
        test_overrun;
        test_clear_overrun;
        test_back_to_back;
        test_reset_mid_drain;
        test_held_rx_done;

        tick; tick;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
